// File: rtl/synth_pkg.sv
// Shared types for the polyphonic mixer: controller states and stereo routing mode.
package synth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATHER = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_SCALE  = 3'd3,
        ST_WRITE  = 3'd4
    } mix_state_e;

    typedef enum logic {
        MODE_MONO  = 1'b0,
        MODE_SPLIT = 1'b1
    } stereo_mode_e;

endpackage

// File: rtl/mix_sat.sv
// One output channel: accumulator times master volume, unity at 2**(VOL_WIDTH-1),
// then saturated to the signed sample range.
module mix_sat
    import synth_pkg::*;
#(
    parameter int ACC_W        = 18,
    parameter int VOL_WIDTH    = 7,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic signed [ACC_W-1:0]        acc,
    input  logic        [VOL_WIDTH-1:0]    vol,
    output logic signed [SAMPLE_WIDTH-1:0] sample,
    output logic                           sat
);

    localparam int PROD_W = ACC_W + VOL_WIDTH + 1;

    localparam logic signed [PROD_W-1:0] MAX_VAL =
        {{(PROD_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] MIN_VAL =
        {{(PROD_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;

    function automatic logic is_sat(input logic signed [PROD_W-1:0] x);
        return (x > MAX_VAL) || (x < MIN_VAL);
    endfunction

    function automatic logic signed [SAMPLE_WIDTH-1:0] saturate(input logic signed [PROD_W-1:0] x);
        if (x > MAX_VAL) begin
            return MAX_VAL[SAMPLE_WIDTH-1:0];
        end else if (x < MIN_VAL) begin
            return MIN_VAL[SAMPLE_WIDTH-1:0];
        end
        return x[SAMPLE_WIDTH-1:0];
    endfunction

    // Volume is an unsigned code; the zero pad keeps the multiply signed-by-positive.
    assign prod    = acc * $signed({1'b0, vol});
    assign shifted = prod >>> (VOL_WIDTH - 1);
    assign sample  = saturate(shifted);
    assign sat     = is_sat(shifted);

endmodule

// File: rtl/poly_mixer.sv
// Frame-based voice mixer: gathers one sample per enabled voice, sums them into
// left/right accumulators one voice per cycle, scales by master volume, writes a frame.
module poly_mixer
    import synth_pkg::*;
#(
    parameter int VOICE_CNT    = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int VOL_WIDTH    = 7
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [VOICE_CNT*SAMPLE_WIDTH-1:0] voice_data_i,
    input  logic [VOICE_CNT-1:0]              voice_val_i,
    output logic [VOICE_CNT-1:0]              voice_rd_o,
    input  logic [VOICE_CNT-1:0]              voice_ena_i,
    input  logic                              stereo_mode_i,
    input  logic [VOL_WIDTH-1:0]              volume_i,
    input  logic                              dac_fifo_almfull_i,
    output logic                              samp_wr_req_o,
    output logic [2*SAMPLE_WIDTH-1:0]         lr_chan_data_o,
    output logic                              clip_o,
    input  logic                              clip_clr_i,
    output logic [15:0]                       frame_cnt_o
);

    localparam int IDX_W = $clog2(VOICE_CNT);
    localparam int ACC_W = SAMPLE_WIDTH + IDX_W;

    mix_state_e                     state;
    mix_state_e                     state_nxt;
    logic [IDX_W-1:0]               idx;
    logic [VOICE_CNT-1:0]           ena_lat;
    stereo_mode_e                   mode_lat;
    logic [VOL_WIDTH-1:0]           vol_lat;
    logic signed [SAMPLE_WIDTH-1:0] samples [VOICE_CNT];
    logic signed [SAMPLE_WIDTH-1:0] cur_sample;
    logic signed [ACC_W-1:0]        sample_ext;
    logic signed [ACC_W-1:0]        acc_l_p0;
    logic signed [ACC_W-1:0]        acc_r_p0;
    logic signed [SAMPLE_WIDTH-1:0] scl_l;
    logic signed [SAMPLE_WIDTH-1:0] scl_r;
    logic                           sat_l;
    logic                           sat_r;
    logic signed [SAMPLE_WIDTH-1:0] frame_l_p1;
    logic signed [SAMPLE_WIDTH-1:0] frame_r_p1;
    logic                           clip;
    logic [15:0]                    frame_cnt;
    logic                           gather_done;
    logic                           accum_last;
    logic                           cur_ena;
    logic                           to_left;
    logic                           to_right;

    for (genvar g = 0; g < VOICE_CNT; g++) begin : g_unpack
        assign samples[g] = voice_data_i[g*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end

    // A disabled voice never blocks the frame, whatever its valid flag says.
    assign gather_done = &(~voice_ena_i | voice_val_i);
    assign accum_last  = (idx == IDX_W'(VOICE_CNT - 1));
    assign cur_sample  = samples[idx];
    assign sample_ext  = {{IDX_W{cur_sample[SAMPLE_WIDTH-1]}}, cur_sample};
    assign cur_ena     = ena_lat[idx];
    assign to_left     = cur_ena && ((mode_lat == MODE_MONO) || !idx[0]);
    assign to_right    = cur_ena && ((mode_lat == MODE_MONO) ||  idx[0]);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   state_nxt = ST_GATHER;
            ST_GATHER: if (gather_done) state_nxt = ST_ACCUM;
            ST_ACCUM:  if (accum_last) state_nxt = ST_SCALE;
            ST_SCALE:  state_nxt = ST_WRITE;
            ST_WRITE:  if (!dac_fifo_almfull_i) state_nxt = ST_GATHER;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        voice_rd_o = '0;
        if (state == ST_ACCUM && cur_ena) begin
            voice_rd_o[idx] = 1'b1;
        end
    end

    assign samp_wr_req_o  = (state == ST_WRITE) && !dac_fifo_almfull_i;
    assign lr_chan_data_o = {frame_l_p1, frame_r_p1};
    assign clip_o         = clip;
    assign frame_cnt_o    = frame_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage 0: frame settings latched, accumulate one voice per ACCUM cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx      <= '0;
            ena_lat  <= '0;
            mode_lat <= MODE_MONO;
            vol_lat  <= '0;
            acc_l_p0 <= '0;
            acc_r_p0 <= '0;
        end else if (state == ST_GATHER && gather_done) begin
            idx      <= '0;
            ena_lat  <= voice_ena_i;
            mode_lat <= stereo_mode_e'(stereo_mode_i);
            vol_lat  <= volume_i;
            acc_l_p0 <= '0;
            acc_r_p0 <= '0;
        end else if (state == ST_ACCUM) begin
            idx <= idx + 1'b1;
            if (to_left) begin
                acc_l_p0 <= acc_l_p0 + sample_ext;
            end
            if (to_right) begin
                acc_r_p0 <= acc_r_p0 + sample_ext;
            end
        end
    end

    mix_sat #(
        .ACC_W        (ACC_W),
        .VOL_WIDTH    (VOL_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_sat_l (
        .acc    (acc_l_p0),
        .vol    (vol_lat),
        .sample (scl_l),
        .sat    (sat_l)
    );

    mix_sat #(
        .ACC_W        (ACC_W),
        .VOL_WIDTH    (VOL_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_sat_r (
        .acc    (acc_r_p0),
        .vol    (vol_lat),
        .sample (scl_r),
        .sat    (sat_r)
    );

    // Stage 1: scaled frame held from SCALE exit until the next SCALE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            frame_l_p1 <= '0;
            frame_r_p1 <= '0;
            clip       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            if (state == ST_SCALE) begin
                frame_l_p1 <= scl_l;
                frame_r_p1 <= scl_r;
            end
            // A fresh saturation outranks a simultaneous clear.
            if (state == ST_SCALE && (sat_l || sat_r)) begin
                clip <= 1'b1;
            end else if (clip_clr_i) begin
                clip <= 1'b0;
            end
            if (samp_wr_req_o) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_poly_mixer.sv
// Self-checking bench for poly_mixer: vector table, hand sequences and randomized
// frames compared against an arithmetic reference model.
module tb_poly_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] voice_data;
    logic [3:0]  voice_val;
    logic [3:0]  voice_rd;
    logic [3:0]  voice_ena;
    logic        stereo_mode;
    logic [6:0]  volume;
    logic        dac_almfull;
    logic        samp_wr_req;
    logic [31:0] lr_chan_data;
    logic        clip_o;
    logic        clip_clr;
    logic [15:0] frame_cnt;

    int   n_checks   = 0;
    int   n_err      = 0;
    int   frames_exp = 0;
    logic exp_clip   = 1'b0;

    typedef struct packed {
        int         s0;
        int         s1;
        int         s2;
        int         s3;
        logic [3:0] ena;
        logic [3:0] val;
        logic       mode;
        int         vol;
        int         exp_l;
        int         exp_r;
        logic       exp_clp;
    } vec_t;

    typedef struct {
        int l;
        int r;
        bit sat;
    } mix_res_t;

    vec_t vecs [7];

    poly_mixer #(
        .VOICE_CNT    (4),
        .SAMPLE_WIDTH (16),
        .VOL_WIDTH    (7)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_n),
        .voice_data_i       (voice_data),
        .voice_val_i        (voice_val),
        .voice_rd_o         (voice_rd),
        .voice_ena_i        (voice_ena),
        .stereo_mode_i      (stereo_mode),
        .volume_i           (volume),
        .dac_fifo_almfull_i (dac_almfull),
        .samp_wr_req_o      (samp_wr_req),
        .lr_chan_data_o     (lr_chan_data),
        .clip_o             (clip_o),
        .clip_clr_i         (clip_clr),
        .frame_cnt_o        (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Unity gain is 64; the arithmetic shift is a floor division.
    function automatic int scale_ch(input longint sum, input int vol, output bit sat);
        longint p;
        longint q;
        p   = sum * vol;
        q   = p / 64;
        if (p < 0 && (p % 64) != 0) q = q - 1;
        sat = 1'b0;
        if (q > 32767) begin
            sat = 1'b1;
            q   = 32767;
        end else if (q < -32768) begin
            sat = 1'b1;
            q   = -32768;
        end
        return int'(q);
    endfunction

    function automatic mix_res_t ref_mix(input int s0, input int s1, input int s2, input int s3,
                                         input logic [3:0] ena, input logic mode, input int vol);
        int       s [4];
        longint   sum_l;
        longint   sum_r;
        bit       sl;
        bit       sr;
        mix_res_t res;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        sum_l = 0;
        sum_r = 0;
        for (int v = 0; v < 4; v++) begin
            if (ena[v]) begin
                if (!mode || (v % 2) == 0) sum_l += s[v];
                if (!mode || (v % 2) == 1) sum_r += s[v];
            end
        end
        res.l   = scale_ch(sum_l, vol, sl);
        res.r   = scale_ch(sum_r, vol, sr);
        res.sat = sl | sr;
        return res;
    endfunction

    // Starts a frame with the DUT waiting in GATHER and follows it to its write strobe.
    task automatic run_frame(input string tag, input int s0, input int s1, input int s2, input int s3,
                             input logic [3:0] ena, input logic [3:0] val, input logic mode,
                             input int vol, input int hold, input logic clr,
                             input int exp_l, input int exp_r, input logic exp_clp);
        logic [3:0]  rd_exp;
        logic [31:0] lr_first;
        logic [31:0] lr_at;
        logic        clip_at;
        int          strobe_at;
        bit          rd_bad;
        strobe_at = -1;
        rd_bad    = 1'b0;
        lr_first  = '0;
        lr_at     = '0;
        clip_at   = 1'b0;
        @(negedge clk);
        voice_data  = {s3[15:0], s2[15:0], s1[15:0], s0[15:0]};
        voice_ena   = ena;
        voice_val   = val;
        stereo_mode = mode;
        volume      = vol[6:0];
        clip_clr    = clr;
        for (int c = 0; c < 30 + hold; c++) begin
            if (c > 0) @(negedge clk);
            dac_almfull = (hold > 0) && (c < 6 + hold);
            #1;
            rd_exp = (c >= 1 && c <= 4) ? (ena & (4'b0001 << (c - 1))) : 4'b0000;
            if (voice_rd !== rd_exp) rd_bad = 1'b1;
            if (c == 6) lr_first = lr_chan_data;
            if (samp_wr_req === 1'b1) begin
                strobe_at = c;
                lr_at     = lr_chan_data;
                clip_at   = clip_o;
                break;
            end
        end
        check({tag, " rd_seq"}, rd_bad, 0);
        check({tag, " latency"}, strobe_at, 6 + hold);
        check({tag, " left"}, $signed(lr_at[31:16]), exp_l);
        check({tag, " right"}, $signed(lr_at[15:0]), exp_r);
        check({tag, " lr_stable"}, lr_at, lr_first);
        check({tag, " clip"}, clip_at, exp_clp);
        voice_val   = 4'b0000;
        voice_ena   = 4'b1111;
        clip_clr    = 1'b0;
        dac_almfull = 1'b0;
        frames_exp++;
        @(negedge clk);
        #1;
        check({tag, " single_strobe"}, samp_wr_req, 0);
        check({tag, " frame_cnt"}, frame_cnt, frames_exp & 16'hFFFF);
    endtask

    initial begin
        mix_res_t         res;
        int               rs [4];
        logic signed [15:0] t;
        logic [3:0]       rena;
        logic             rmode;
        int               rvol;
        int               rhold;

        vecs[0] = '{1000, 2000, -500, 100, 4'hF, 4'hF, 1'b0, 64, 2600, 2600, 1'b0};
        vecs[1] = '{1000, 2000, -500, 100, 4'hF, 4'hF, 1'b1, 64, 500, 2100, 1'b0};
        vecs[2] = '{1000, 2000, -500, 100, 4'hF, 4'hF, 1'b0, 0, 0, 0, 1'b0};
        vecs[3] = '{1000, 2000, -500, 100, 4'hF, 4'hF, 1'b0, 127, 5159, 5159, 1'b0};
        vecs[4] = '{-1000, -2000, 500, -100, 4'hF, 4'hF, 1'b1, 127, -993, -4168, 1'b0};
        vecs[5] = '{1000, 2000, -500, 100, 4'b0101, 4'b0101, 1'b0, 64, 500, 500, 1'b0};
        vecs[6] = '{-30000, -30000, -30000, -30000, 4'hF, 4'hF, 1'b0, 64, -32768, -32768, 1'b1};

        rst_n       = 1'b0;
        voice_data  = '0;
        voice_val   = 4'b0000;
        voice_ena   = 4'b1111;
        stereo_mode = 1'b0;
        volume      = 7'd64;
        dac_almfull = 1'b0;
        clip_clr    = 1'b0;
        #1;
        check("reset rd", voice_rd, 0);
        check("reset wr", samp_wr_req, 0);
        check("reset lr", lr_chan_data, 0);
        check("reset clip", clip_o, 0);
        check("reset frame_cnt", frame_cnt, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3,
                      vecs[i].ena, vecs[i].val, vecs[i].mode, vecs[i].vol, 0, 1'b0,
                      vecs[i].exp_l, vecs[i].exp_r, vecs[i].exp_clp);
        end

        // Saturating frame with clear held high throughout: the saturation must win.
        @(negedge clk);
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        #1;
        check("clip pre-clear", clip_o, 0);
        run_frame("sat", 30000, 30000, 30000, 30000, 4'hF, 4'hF, 1'b0, 64, 0, 1'b1,
                  32767, 32767, 1'b1);
        @(negedge clk);
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        #1;
        check("clip clear", clip_o, 0);
        exp_clip = 1'b0;

        run_frame("backpressure", 1000, 2000, -500, 100, 4'hF, 4'hF, 1'b0, 64, 10, 1'b0,
                  2600, 2600, 1'b0);
        run_frame("zero_mask", 1000, 2000, -500, 100, 4'h0, 4'h0, 1'b0, 64, 0, 1'b0,
                  0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            for (int v = 0; v < 4; v++) begin
                t     = 16'($urandom);
                rs[v] = int'(t);
            end
            rena  = 4'($urandom);
            rmode = 1'($urandom);
            rvol  = int'($urandom_range(0, 127));
            rhold = int'($urandom_range(0, 3));
            res   = ref_mix(rs[0], rs[1], rs[2], rs[3], rena, rmode, rvol);
            exp_clip = exp_clip | res.sat;
            run_frame($sformatf("rand%0d", n), rs[0], rs[1], rs[2], rs[3], rena,
                      rena | 4'($urandom), rmode, rvol, rhold, 1'b0, res.l, res.r, exp_clip);
        end

        // Make clip and the output frame non-zero, then reset in the 2nd ACCUM cycle.
        run_frame("pre_reset", 30000, 30000, 30000, 30000, 4'hF, 4'hF, 1'b0, 64, 0, 1'b0,
                  32767, 32767, 1'b1);
        @(negedge clk);
        voice_data  = {16'sd100, -16'sd500, 16'sd2000, 16'sd1000};
        voice_ena   = 4'hF;
        voice_val   = 4'hF;
        stereo_mode = 1'b0;
        volume      = 7'd64;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("accum2 rd", voice_rd, 4'b0010);
        rst_n = 1'b0;
        #1;
        check("mid-reset rd", voice_rd, 0);
        check("mid-reset wr", samp_wr_req, 0);
        check("mid-reset lr", lr_chan_data, 0);
        check("mid-reset clip", clip_o, 0);
        check("mid-reset frame_cnt", frame_cnt, 0);
        voice_val = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int strobes;
            strobes = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                #1;
                if (samp_wr_req === 1'b1) strobes++;
            end
            check("no write after reset", strobes, 0);
        end
        check("post-reset frame_cnt", frame_cnt, 0);
        frames_exp = 0;
        run_frame("post_reset", 1000, 2000, -500, 100, 4'hF, 4'hF, 1'b0, 64, 0, 1'b0,
                  2600, 2600, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
